// File: rtl/mem_bist_pkg.sv
// ============================================================================
// mem_bist_pkg : FSM state encoding and data-pattern helper for mem_bist
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR_UP = 3'd1,
        S_RD_UP = 3'd2,
        S_WR_DN = 3'd3,
        S_RD_DN = 3'd4,
        S_DRAIN = 3'd5,
        S_FIN   = 3'd6
    } bist_state_e;

    // Computed at 64 bits; callers size-cast, which gives the zero-extend/truncate behaviour.
    function automatic logic [63:0] bist_pattern(input logic [63:0] i_addr,
                                                 input logic [63:0] i_seed);
        return i_addr ^ i_seed;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bist_if.sv
// ============================================================================
// mem_bist_if : single-port synchronous memory bus between BIST and memory
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_bist_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) ();
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (output read, output write, output addr, output data_in, input data_out);
    modport slave  (input read, input write, input addr, input data_in, output data_out);
endinterface

`default_nettype wire

// File: rtl/mem_bist_cmp.sv
// ============================================================================
// mem_bist_cmp : registered read-compare stage; lines up the issued read with
//                the memory data returned one cycle later
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_bist_cmp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_exp,
    input  logic [DATA_WIDTH-1:0] i_act,
    output logic                  o_mismatch,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_exp,
    output logic [DATA_WIDTH-1:0] o_act
);

    logic                  r_valid;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_exp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_exp   <= '0;
        end else begin
            r_valid <= i_valid;
            r_addr  <= i_addr;
            r_exp   <= i_exp;
        end
    end

    assign o_mismatch = r_valid && (i_act != r_exp);
    assign o_addr     = r_addr;
    assign o_exp      = r_exp;
    assign o_act      = i_act;

endmodule

`default_nettype wire

// File: rtl/mem_bist.sv
// ============================================================================
// mem_bist : march-style memory BIST (write/read up, inverted write/read down)
//            with first-failure capture
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_bist
    import mem_bist_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 5,
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] PATTERN_SEED = DATA_WIDTH'('hA5)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_exp,
    output logic [DATA_WIDTH-1:0] fail_act,
    mem_bist_if.master            mem
);

    localparam logic [ADDR_WIDTH-1:0] c_addr_last = '1;

    bist_state_e           r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_pass, w_pass_nxt;
    logic [ADDR_WIDTH-1:0] r_fail_addr, w_fail_addr_nxt;
    logic [DATA_WIDTH-1:0] r_fail_exp, w_fail_exp_nxt;
    logic [DATA_WIDTH-1:0] r_fail_act, w_fail_act_nxt;
    logic                  r_read, w_read_nxt;
    logic                  r_write, w_write_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_data, w_data_nxt;

    logic [DATA_WIDTH-1:0] w_pat_cur, w_pat_nxt, w_exp_cur;
    logic                  w_mismatch;
    logic [ADDR_WIDTH-1:0] w_cmp_addr;
    logic [DATA_WIDTH-1:0] w_cmp_exp, w_cmp_act;

    assign w_pat_cur = DATA_WIDTH'(bist_pattern(64'(r_addr), 64'(PATTERN_SEED)));
    assign w_pat_nxt = DATA_WIDTH'(bist_pattern(64'(w_cnt_nxt), 64'(PATTERN_SEED)));
    assign w_exp_cur = (r_state == S_RD_DN) ? ~w_pat_cur : w_pat_cur;

    mem_bist_cmp #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmp (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (r_read),
        .i_addr     (r_addr),
        .i_exp      (w_exp_cur),
        .i_act      (mem.data_out),
        .o_mismatch (w_mismatch),
        .o_addr     (w_cmp_addr),
        .o_exp      (w_cmp_exp),
        .o_act      (w_cmp_act)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_done_nxt      = r_done;
        w_pass_nxt      = r_pass;
        w_fail_addr_nxt = r_fail_addr;
        w_fail_exp_nxt  = r_fail_exp;
        w_fail_act_nxt  = r_fail_act;

        case (r_state)
            S_IDLE, S_FIN: begin
                if (start) begin
                    w_state_nxt     = S_WR_UP;
                    w_cnt_nxt       = '0;
                    w_done_nxt      = 1'b0;
                    w_pass_nxt      = 1'b0;
                    w_fail_addr_nxt = '0;
                    w_fail_exp_nxt  = '0;
                    w_fail_act_nxt  = '0;
                end
            end
            S_WR_UP: begin
                if (r_cnt == c_addr_last) begin
                    w_state_nxt = S_RD_UP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RD_UP: begin
                if (r_cnt == c_addr_last) begin
                    w_state_nxt = S_WR_DN;
                    w_cnt_nxt   = c_addr_last;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WR_DN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_RD_DN;
                    w_cnt_nxt   = c_addr_last;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_RD_DN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_FIN;
                w_done_nxt  = 1'b1;
                w_pass_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A mismatch overrides normal sequencing, including the DRAIN pass verdict.
        if (w_mismatch) begin
            w_state_nxt     = S_FIN;
            w_cnt_nxt       = '0;
            w_done_nxt      = 1'b1;
            w_pass_nxt      = 1'b0;
            w_fail_addr_nxt = w_cmp_addr;
            w_fail_exp_nxt  = w_cmp_exp;
            w_fail_act_nxt  = w_cmp_act;
        end

        w_busy_nxt  = (w_state_nxt != S_IDLE) && (w_state_nxt != S_FIN);
        w_read_nxt  = (w_state_nxt == S_RD_UP) || (w_state_nxt == S_RD_DN);
        w_write_nxt = (w_state_nxt == S_WR_UP) || (w_state_nxt == S_WR_DN);
        w_addr_nxt  = (w_read_nxt || w_write_nxt) ? w_cnt_nxt : '0;
        if (w_state_nxt == S_WR_UP) begin
            w_data_nxt = w_pat_nxt;
        end else if (w_state_nxt == S_WR_DN) begin
            w_data_nxt = ~w_pat_nxt;
        end else begin
            w_data_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_exp  <= '0;
            r_fail_act  <= '0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_fail_addr <= w_fail_addr_nxt;
            r_fail_exp  <= w_fail_exp_nxt;
            r_fail_act  <= w_fail_act_nxt;
            r_read      <= w_read_nxt;
            r_write     <= w_write_nxt;
            r_addr      <= w_addr_nxt;
            r_data      <= w_data_nxt;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail_addr   = r_fail_addr;
    assign fail_exp    = r_fail_exp;
    assign fail_act    = r_fail_act;
    assign mem.read    = r_read;
    assign mem.write   = r_write;
    assign mem.addr    = r_addr;
    assign mem.data_in = r_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_bist.sv
// ============================================================================
// tb_mem_bist : self-checking bench for mem_bist with a stuck-bit memory model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_bist;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int D  = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy, done, pass;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_exp, fail_act;

    mem_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    mem_bist #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .PATTERN_SEED (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_exp  (fail_exp),
        .fail_act  (fail_act),
        .mem       (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Injected fault: one bit of one word reads back stuck at f_val.
    bit f_en   = 1'b0;
    int f_addr = 0;
    int f_bit  = 0;
    bit f_val  = 1'b0;

    logic [DW-1:0] mem_arr [D];

    function automatic logic [DW-1:0] fault_rd(input logic [DW-1:0] v, input int a);
        logic [DW-1:0] r;
        r = v;
        if (f_en && a == f_addr) r[f_bit] = f_val;
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_if.write) mem_arr[mem_if.addr] <= mem_if.data_in;
        if (mem_if.read)  mem_if.data_out <= fault_rd(mem_arr[mem_if.addr], int'(mem_if.addr));
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int a);
        return DW'(a) ^ 8'hA5;
    endfunction

    // Whole-test outcome worked out by walking the march element by element.
    function automatic void model(output bit e_pass, output logic [AW-1:0] e_addr,
                                  output logic [DW-1:0] e_exp, output logic [DW-1:0] e_act,
                                  output int e_busy);
        logic [DW-1:0] m [D];
        logic [DW-1:0] got;
        e_pass = 1'b1; e_addr = '0; e_exp = '0; e_act = '0; e_busy = 4*D + 1;
        for (int a = 0; a < D; a++) m[a] = pat(a);
        for (int a = 0; a < D; a++) begin
            got = fault_rd(m[a], a);
            if (got != pat(a)) begin
                e_pass = 1'b0; e_addr = AW'(a); e_exp = pat(a); e_act = got;
                e_busy = D + a + 2;
                return;
            end
        end
        for (int a = 0; a < D; a++) m[a] = ~pat(a);
        for (int i = 0; i < D; i++) begin
            int a;
            a = D - 1 - i;
            got = fault_rd(m[a], a);
            if (got != ~pat(a)) begin
                e_pass = 1'b0; e_addr = AW'(a); e_exp = ~pat(a); e_act = got;
                e_busy = 3*D + i + 2;
                return;
            end
        end
    endfunction

    // Memory access expected in busy cycle k: {read, write, addr, data_in}.
    function automatic logic [14:0] exp_bus(input int k);
        if (k < D)        return {1'b0, 1'b1, AW'(k), pat(k)};
        else if (k < 2*D) return {1'b1, 1'b0, AW'(k - D), 8'h00};
        else if (k < 3*D) return {1'b0, 1'b1, AW'(3*D - 1 - k), ~pat(3*D - 1 - k)};
        else if (k < 4*D) return {1'b1, 1'b0, AW'(4*D - 1 - k), 8'h00};
        else              return 15'd0;
    endfunction

    task automatic run(input string tag, input int restart_k, input int rst_k);
        bit            e_pass;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_exp, e_act;
        int            e_busy;
        int            k;
        model(e_pass, e_addr, e_exp, e_act, e_busy);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = 0;
        while (busy === 1'b1 && k < 300) begin
            check({tag, "_bus"}, 64'({mem_if.read, mem_if.write, mem_if.addr, mem_if.data_in}),
                  64'(exp_bus(k)));
            if (k == 0)
                check({tag, "_clr"}, 64'({done, pass, fail_addr, fail_exp, fail_act}), 64'd0);
            if (k == rst_k) begin
                start = 1'b0;
                rst   = 1'b1;
                @(negedge clk);
                check({tag, "_rst_outs"}, 64'({busy, done, pass, fail_addr, fail_exp, fail_act,
                      mem_if.read, mem_if.write, mem_if.addr, mem_if.data_in}), 64'd0);
                rst = 1'b0;
                @(negedge clk);
                check({tag, "_rst_quiet"}, 64'({busy, mem_if.read, mem_if.write}), 64'd0);
                return;
            end
            start = (k == restart_k);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check({tag, "_busy_len"}, 64'(k), 64'(e_busy));
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_pass"}, 64'(pass), 64'(e_pass));
        check({tag, "_fail_addr"}, 64'(fail_addr), 64'(e_addr));
        check({tag, "_fail_exp"}, 64'(fail_exp), 64'(e_exp));
        check({tag, "_fail_act"}, 64'(fail_act), 64'(e_act));
        check({tag, "_idle_bus"}, 64'({mem_if.read, mem_if.write, mem_if.addr, mem_if.data_in}),
              64'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs", 64'({busy, done, pass, fail_addr, fail_exp, fail_act,
              mem_if.read, mem_if.write, mem_if.addr, mem_if.data_in}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        f_en = 1'b0;
        run("clean", -1, -1);
        f_en = 1'b1; f_addr = 3; f_bit = 0; f_val = 1'b1;
        run("sa1_a3", -1, -1);
        check("sa1_a3_exact", 64'({fail_addr, fail_exp, fail_act}), 64'({5'd3, 8'hA6, 8'hA7}));
        f_val = 1'b0;
        run("sa0_a3", -1, -1);
        check("sa0_a3_exact", 64'({fail_addr, fail_exp, fail_act}), 64'({5'd3, 8'h59, 8'h58}));
        f_en = 1'b0;
        run("restart10", 10, -1);
        run("rst40", -1, 40);
        run("after_rst", -1, -1);

        // Random fault locations, polarities and stray start pulses
        for (int t = 0; t < 24; t++) begin
            f_en   = ($urandom_range(0, 3) != 0);
            f_addr = int'($urandom_range(0, D - 1));
            f_bit  = int'($urandom_range(0, DW - 1));
            f_val  = 1'($urandom_range(0, 1));
            run($sformatf("rnd%0d", t), ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 140)) : -1,
                -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
